logic_op_pipe: RTL and testbench

//  Parametrised, pipelined bitwise logic unit: successor to the fixed 2-input gate cells.

---
 rtl/logic_op_pipe.sv | 105 ++++++++++
 tb/tb_logic_op_pipe.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_op_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// logic_op_pipe : runtime-selected bitwise op feeding a valid/ready pipeline
// Revision 1.0
// ---------------------------------------------------------------------------
module logic_op_pipe #(
  parameter int WIDTH   = 8,
  parameter int STAGES  = 2,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [2:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  input  logic               flush,
  input  logic               cnt_clr,
  output logic [COUNT_W-1:0] op_count,
  output logic               busy
);

  localparam int LAST = STAGES - 1;

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] adv;
  logic [WIDTH-1:0]  d [STAGES];
  logic [WIDTH-1:0]  result;
  logic              accept;
  logic              hs;
  logic              hole;

  always_comb begin
    result = '0;
    case (in_op)
      3'd0:    result = ~(in_a | in_b);
      3'd1:    result = ~(in_a & in_b);
      3'd2:    result = in_a & in_b;
      3'd3:    result = in_a | in_b;
      3'd4:    result = in_a ^ in_b;
      3'd5:    result = ~(in_a ^ in_b);
      3'd6:    result = ~in_a;
      default: result = in_a;
    endcase
  end

  // A stage moves on when the sink takes the head or any later stage has a hole.
  always_comb begin
    adv  = '0;
    hole = 1'b0;
    for (int k = LAST; k >= 0; k--) begin
      adv[k] = v[k] & (out_ready | hole);
      hole   = hole | ~v[k];
    end
  end

  assign in_ready = ~v[0] | adv[0];
  assign accept   = in_valid & in_ready;
  assign hs       = v[LAST] & out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             load;
    logic [WIDTH-1:0] src;

    if (k == 0) begin : g_head
      assign load = accept;
      assign src  = result;
    end else begin : g_body
      assign load = adv[k-1];
      assign src  = d[k-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v[k] <= 1'b0;
        d[k] <= '0;
      end else begin
        if (flush)       v[k] <= 1'b0;
        else if (load)   v[k] <= 1'b1;
        else if (adv[k]) v[k] <= 1'b0;
        if (load) d[k] <= src;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      op_count <= '0;
    else if (cnt_clr)
      op_count <= '0;
    else if (hs && !flush && !(&op_count))
      op_count <= op_count + 1'b1;
  end

  assign out_valid = v[LAST];
  assign out_data  = d[LAST];
  assign busy      = |v;

endmodule
`default_nettype wire

// File: tb/tb_logic_op_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_logic_op_pipe : directed stimulus, slot-array model and literal checks
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_logic_op_pipe;

  localparam int STAGES = 2;
  localparam int L      = STAGES - 1;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [2:0] in_op;
  logic       out_ready;
  logic       flush;
  logic       cnt_clr;

  logic        in_ready,  out_valid,  busy;
  logic [7:0]  out_data;
  logic [15:0] op_count;
  logic        in_ready4, out_valid4, busy4;
  logic [7:0]  out_data4;
  logic [3:0]  op_count4;

  logic_op_pipe #(.WIDTH(8), .STAGES(STAGES), .COUNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .flush(flush),
    .cnt_clr(cnt_clr), .op_count(op_count), .busy(busy)
  );

  logic_op_pipe #(.WIDTH(8), .STAGES(STAGES), .COUNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid4),
    .out_ready(out_ready), .out_data(out_data4), .flush(flush),
    .cnt_clr(cnt_clr), .op_count(op_count4), .busy(busy4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] golden(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0:    return ~(a | b);
      3'd1:    return ~(a & b);
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~(a ^ b);
      3'd6:    return ~a;
      default: return a;
    endcase
  endfunction

  // Model: STAGES slots; each edge the head may leave, entries slide into holes,
  // then a new beat may enter slot 0.
  bit   [STAGES-1:0] m_v = '0;
  logic [7:0]        m_d [STAGES];
  int                m_cnt = 0;
  bit   [STAGES-1:0] tv;
  logic [7:0]        td [STAGES];
  int                tc;

  function automatic bit m_in_ready();
    return !(&m_v) || out_ready;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_v   <= '0;
      m_cnt <= 0;
    end else begin
      tv = m_v;
      td = m_d;
      tc = m_cnt;
      if (flush) begin
        tv = '0;
      end else begin
        if (tv[L] && out_ready) begin
          tc++;
          tv[L] = 1'b0;
        end
        for (int k = L - 1; k >= 0; k--) begin
          if (tv[k] && !tv[k+1]) begin
            tv[k+1] = 1'b1;
            td[k+1] = td[k];
            tv[k]   = 1'b0;
          end
        end
        if (in_valid && m_in_ready()) begin
          tv[0] = 1'b1;
          td[0] = golden(in_op, in_a, in_b);
        end
      end
      if (cnt_clr) tc = 0;
      m_v   <= tv;
      m_d   <= td;
      m_cnt <= tc;
    end
  end

  always @(negedge clk) begin
    check("in_ready",   {31'd0, in_ready},   {31'd0, m_in_ready()});
    check("out_valid",  {31'd0, out_valid},  {31'd0, m_v[L]});
    check("busy",       {31'd0, busy},       {31'd0, |m_v});
    check("op_count",   {16'd0, op_count},   (m_cnt > 65535) ? 32'd65535 : m_cnt);
    check("in_ready4",  {31'd0, in_ready4},  {31'd0, m_in_ready()});
    check("out_valid4", {31'd0, out_valid4}, {31'd0, m_v[L]});
    check("op_count4",  {28'd0, op_count4},  (m_cnt > 15) ? 32'd15 : m_cnt);
    if (m_v[L]) begin
      check("out_data",  {24'd0, out_data},  {24'd0, m_d[L]});
      check("out_data4", {24'd0, out_data4}, {24'd0, m_d[L]});
    end
  end

  logic [7:0] got [$];
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !flush) got.push_back(out_data);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setin(input bit v, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_op    = op;
  endtask

  logic [7:0] t2_exp [8];
  logic [7:0] t3_exp [3];

  initial begin
    t2_exp = '{8'h42, 8'hDB, 8'h24, 8'hBD, 8'h99, 8'h66, 8'h5A, 8'hA5};
    t3_exp = '{8'h33, 8'h30, 8'hF0};
    rst_n = 1'b0; out_ready = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
    setin(0, 8'h00, 8'h00, 3'd0);
    repeat (2) step();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data",  {24'd0, out_data},  32'd0);
    check("rst_op_count",  {16'd0, op_count},  32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    rst_n = 1'b1;
    step();
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);

    // T1: NOR 0x0F,0x30 -> 0xC0 two cycles after accept
    out_ready = 1'b1;
    setin(1, 8'h0F, 8'h30, 3'd0);
    step();
    setin(0, 8'h00, 8'h00, 3'd0);
    check("t1_not_yet", {31'd0, out_valid}, 32'd0);
    step();
    check("t1_valid", {31'd0, out_valid}, 32'd1);
    check("t1_data",  {24'd0, out_data},  32'hC0);
    step();
    check("t1_count", {16'd0, op_count}, 32'd1);
    got.delete();

    // T2: back-to-back sweep of all ops
    for (int op = 0; op < 8; op++) begin
      setin(1, 8'hA5, 8'h3C, op[2:0]);
      step();
    end
    setin(0, 8'h00, 8'h00, 3'd0);
    repeat (4) step();
    check("t2_len", got.size(), 32'd8);
    for (int i = 0; i < 8; i++)
      if (i < got.size()) check($sformatf("t2_res%0d", i), {24'd0, got[i]}, {24'd0, t2_exp[i]});
    got.delete();

    // T3: backpressure fills the pipe, release drains in order
    out_ready = 1'b0;
    setin(1, 8'h11, 8'h22, 3'd3);
    step();
    setin(1, 8'hF0, 8'h3C, 3'd2);
    check("t3_ready_b2", {31'd0, in_ready}, 32'd1);
    step();
    setin(1, 8'hFF, 8'h0F, 3'd4);
    check("t3_full", {31'd0, in_ready}, 32'd0);
    step();
    check("t3_still_full", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    #1;
    check("t3_release", {31'd0, in_ready}, 32'd1);
    step();
    setin(0, 8'h00, 8'h00, 3'd0);
    repeat (3) step();
    check("t3_len", got.size(), 32'd3);
    for (int i = 0; i < 3; i++)
      if (i < got.size()) check($sformatf("t3_res%0d", i), {24'd0, got[i]}, {24'd0, t3_exp[i]});
    check("t3_count", {16'd0, op_count}, 32'd12);

    // T4: flush with two in flight plus a presented beat and a ready sink
    out_ready = 1'b0;
    setin(1, 8'h77, 8'h00, 3'd7);
    step();
    setin(1, 8'h66, 8'h00, 3'd7);
    step();
    setin(1, 8'h55, 8'h00, 3'd7);
    flush = 1'b1;
    out_ready = 1'b1;
    step();
    flush = 1'b0;
    setin(0, 8'h00, 8'h00, 3'd0);
    check("t4_busy",      {31'd0, busy},      32'd0);
    check("t4_out_valid", {31'd0, out_valid}, 32'd0);
    check("t4_count",     {16'd0, op_count},  32'd12);
    repeat (2) step();
    check("t4_no_ghost",  {31'd0, out_valid}, 32'd0);
    check("t4_count2",    {16'd0, op_count},  32'd12);

    // T5: saturation on a 4-bit counter, clear beats simultaneous handshake
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check("t5_clr", {16'd0, op_count}, 32'd0);
    for (int i = 0; i < 17; i++) begin
      setin(1, i[7:0], ~i[7:0], 3'd4);
      step();
    end
    setin(0, 8'h00, 8'h00, 3'd0);
    repeat (3) step();
    check("t5_sat4",   {28'd0, op_count4}, 32'd15);
    check("t5_count",  {16'd0, op_count},  32'd17);
    setin(1, 8'h12, 8'h34, 3'd3);
    step();
    setin(0, 8'h00, 8'h00, 3'd0);
    step();
    check("t5_hs_valid", {31'd0, out_valid}, 32'd1);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check("t5_clr_wins4", {28'd0, op_count4}, 32'd0);
    check("t5_clr_wins",  {16'd0, op_count},  32'd0);
    check("t5_drained",   {31'd0, out_valid}, 32'd0);

    // T6: asynchronous reset between edges, then clean restart
    setin(1, 8'h01, 8'h00, 3'd7);
    step();
    setin(1, 8'h02, 8'h00, 3'd7);
    step();
    setin(1, 8'h03, 8'h00, 3'd7);
    step();
    setin(0, 8'h00, 8'h00, 3'd0);
    check("t6_pre_count", {16'd0, op_count}, 32'd1);
    check("t6_pre_busy",  {31'd0, busy},     32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_out_valid", {31'd0, out_valid}, 32'd0);
    check("t6_count",     {16'd0, op_count},  32'd0);
    check("t6_count4",    {28'd0, op_count4}, 32'd0);
    check("t6_busy",      {31'd0, busy},      32'd0);
    check("t6_data",      {24'd0, out_data},  32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("t6_in_ready", {31'd0, in_ready}, 32'd1);
    setin(1, 8'h5A, 8'h00, 3'd7);
    step();
    setin(0, 8'h00, 8'h00, 3'd0);
    step();
    check("t6_resume_valid", {31'd0, out_valid}, 32'd1);
    check("t6_resume_data",  {24'd0, out_data},  32'h5A);
    step();
    check("t6_resume_count", {16'd0, op_count},  32'd1);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
